mc_control_unit: RTL and testbench



---
 rtl/mc_ctrl_pkg.sv | 64 ++++++
 rtl/mc_ctrl_decode.sv | 71 +++++++
 rtl/mc_control_unit.sv | 157 +++++++++++++++
 tb/tb_mc_control_unit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: states, opcodes,
// funct codes, ALU operations and datapath select values.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EXE  = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100,
    S_HALT = 3'b111
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b100
  } alu_op_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_RS     = 2'b10;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b11;

  localparam logic [1:0] REG_DST_RA = 2'b00;
  localparam logic [1:0] REG_DST_RT = 2'b01;
  localparam logic [1:0] REG_DST_RD = 2'b10;

  // One-hot instruction class produced by the decoder.
  typedef struct packed {
    logic rtype;
    logic jr;
    logic imm_arith;
    logic load;
    logic store;
    logic branch;
    logic jump;
    logic link;
    logic halt;
    logic illegal;
  } iclass_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction decoder: op/funct to one-hot class flags plus
// the ALU operation and the few per-instruction qualifiers the top needs.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output iclass_t    cls,
  output logic       funct_ok,
  output logic       is_bne,
  output logic       zero_ext,
  output alu_op_t    alu_sel
);

  // Class flags and ALU operation from the opcode, refined by funct for R-type.
  always_comb begin
    cls      = '0;
    funct_ok = 1'b0;
    is_bne   = 1'b0;
    zero_ext = 1'b0;
    alu_sel  = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        if (funct == FN_JR) begin
          cls.jr = 1'b1;
        end else begin
          // Unknown funct still flows through EXE/WB as rtype, but never writes.
          cls.rtype = 1'b1;
          funct_ok  = 1'b1;
          case (funct)
            FN_ADD:  alu_sel = ALU_ADD;
            FN_SUB:  alu_sel = ALU_SUB;
            FN_AND:  alu_sel = ALU_AND;
            FN_OR:   alu_sel = ALU_OR;
            FN_SLT:  alu_sel = ALU_SLT;
            default: funct_ok = 1'b0;
          endcase
        end
      end
      OP_ADDI: begin
        cls.imm_arith = 1'b1;
        alu_sel       = ALU_ADD;
      end
      OP_ORI: begin
        cls.imm_arith = 1'b1;
        zero_ext      = 1'b1;
        alu_sel       = ALU_OR;
      end
      OP_SLTI: begin
        cls.imm_arith = 1'b1;
        alu_sel       = ALU_SLT;
      end
      OP_LW:   cls.load  = 1'b1;
      OP_SW:   cls.store = 1'b1;
      OP_BEQ: begin
        cls.branch = 1'b1;
        alu_sel    = ALU_SUB;
      end
      OP_BNE: begin
        cls.branch = 1'b1;
        is_bne     = 1'b1;
        alu_sel    = ALU_SUB;
      end
      OP_J:    cls.jump    = 1'b1;
      OP_JAL:  cls.link    = 1'b1;
      OP_HALT: cls.halt    = 1'b1;
      default: cls.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle MIPS control unit: state register for IF/ID/EXE/MEM/WB/HALT and
// combinational datapath controls derived from state, op/funct and zero.
//
// state | meaning
// ------+-----------------------------------------------------------
// IF    | fetch: load IR
// ID    | decode; j/jal/jr/unknown op finish here, jal writes $31
// EXE   | ALU operation; beq/bne resolve and finish here
// MEM   | data-memory access; sw finishes here
// WB    | register write-back; always returns to IF
// HALT  | sticky stop, all enables low until rst
module mc_control_unit
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_wre,
  output logic       ir_wre,
  output logic       reg_wre,
  output logic [1:0] reg_dst,
  output logic       wr_data_src,
  output logic       mem_to_reg,
  output logic       alu_src_b,
  output logic       ext_sel,
  output logic [2:0] alu_op,
  output logic [1:0] pc_src,
  output logic       mem_wr,
  output logic [2:0] state
);

  iclass_t cls;
  logic    funct_ok;
  logic    is_bne;
  logic    zero_ext;
  alu_op_t alu_sel;
  state_t  cur;
  logic    last;
  logic    alu_drive;

  mc_ctrl_decode u_decode (
    .op       (op),
    .funct    (funct),
    .cls      (cls),
    .funct_ok (funct_ok),
    .is_bne   (is_bne),
    .zero_ext (zero_ext),
    .alu_sel  (alu_sel)
  );

  assign state = cur;

  // State register and transitions; undefined encodings recover to IF.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur <= S_IF;
    end else begin
      case (cur)
        S_IF: cur <= S_ID;
        S_ID: begin
          if (cls.halt)
            cur <= S_HALT;
          else if (cls.jr || cls.jump || cls.link || cls.illegal)
            cur <= S_IF;
          else
            cur <= S_EXE;
        end
        S_EXE: begin
          if (cls.branch)
            cur <= S_IF;
          else if (cls.load || cls.store)
            cur <= S_MEM;
          else
            cur <= S_WB;
        end
        S_MEM:   cur <= cls.load ? S_WB : S_IF;
        S_WB:    cur <= S_IF;
        S_HALT:  cur <= S_HALT;
        default: cur <= S_IF;
      endcase
    end
  end

  // Final cycle of the instruction: the one whose successor is IF.
  always_comb begin
    last = 1'b0;
    case (cur)
      S_ID:    last = cls.jr || cls.jump || cls.link || cls.illegal;
      S_EXE:   last = cls.branch;
      S_MEM:   last = cls.store;
      S_WB:    last = 1'b1;
      default: last = 1'b0;
    endcase
  end

  // Datapath controls; enables are suppressed while rst is high.
  always_comb begin
    pc_wre      = 1'b0;
    ir_wre      = 1'b0;
    reg_wre     = 1'b0;
    reg_dst     = REG_DST_RT;
    wr_data_src = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_b   = 1'b0;
    ext_sel     = 1'b0;
    alu_op      = ALU_ADD;
    pc_src      = PC_SRC_SEQ;
    mem_wr      = 1'b0;
    alu_drive   = 1'b0;

    case (cur)
      S_IF: ir_wre = 1'b1;
      S_ID: begin
        if (cls.link) begin
          reg_wre     = 1'b1;
          reg_dst     = REG_DST_RA;
          wr_data_src = 1'b1;
        end
      end
      S_EXE: alu_drive = 1'b1;
      S_MEM: mem_wr = cls.store;
      S_WB: begin
        alu_drive  = 1'b1;
        reg_wre    = !(cls.rtype && !funct_ok);
        reg_dst    = cls.rtype ? REG_DST_RD : REG_DST_RT;
        mem_to_reg = cls.load;
      end
      default: ;
    endcase

    if (alu_drive) begin
      alu_src_b = cls.imm_arith || cls.load || cls.store;
      ext_sel   = !zero_ext;
      alu_op    = alu_sel;
    end

    if (last) begin
      pc_wre = 1'b1;
      if (cls.jr)
        pc_src = PC_SRC_RS;
      else if (cls.jump || cls.link)
        pc_src = PC_SRC_JUMP;
      else if (cls.branch && (zero ^ is_bne))
        pc_src = PC_SRC_BRANCH;
    end

    if (rst) begin
      pc_wre  = 1'b0;
      ir_wre  = 1'b0;
      reg_wre = 1'b0;
      mem_wr  = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// Testbench for mc_control_unit: instruction-level reference model checked
// every cycle, plus directed literal checks of the headline scenarios.
module tb_mc_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op, funct;
  logic       zero;
  logic       pc_wre, ir_wre, reg_wre, wr_data_src, mem_to_reg, alu_src_b, ext_sel, mem_wr;
  logic [1:0] reg_dst, pc_src;
  logic [2:0] alu_op, state;

  int checks = 0;
  int errors = 0;

  localparam int K_R = 0, K_RNOP = 1, K_JR = 2, K_ADDI = 3, K_ORI = 4, K_SLTI = 5,
                 K_LW = 6, K_SW = 7, K_BEQ = 8, K_BNE = 9, K_J = 10, K_JAL = 11,
                 K_HALT = 12, K_ILL = 13;

  int m_k, m_i, m_len;
  bit m_valid = 1'b0;

  mc_control_unit dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
    .pc_wre(pc_wre), .ir_wre(ir_wre), .reg_wre(reg_wre), .reg_dst(reg_dst),
    .wr_data_src(wr_data_src), .mem_to_reg(mem_to_reg), .alu_src_b(alu_src_b),
    .ext_sel(ext_sel), .alu_op(alu_op), .pc_src(pc_src), .mem_wr(mem_wr),
    .state(state)
  );

  always #5 clk = ~clk;

  function automatic int classify(input logic [5:0] o, input logic [5:0] f);
    case (o)
      6'b000000: begin
        if (f == 6'b001000) return K_JR;
        if (f == 6'b100000 || f == 6'b100010 || f == 6'b100100 ||
            f == 6'b100101 || f == 6'b101010) return K_R;
        return K_RNOP;
      end
      6'b001000: return K_ADDI;
      6'b001101: return K_ORI;
      6'b001010: return K_SLTI;
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b000100: return K_BEQ;
      6'b000101: return K_BNE;
      6'b000010: return K_J;
      6'b000011: return K_JAL;
      6'b111111: return K_HALT;
      default:   return K_ILL;
    endcase
  endfunction

  // Cycle count per instruction class (from the CPI table).
  function automatic int cpi(input int k);
    case (k)
      K_J, K_JAL, K_JR, K_ILL: return 2;
      K_BEQ, K_BNE:            return 3;
      K_LW:                    return 5;
      default:                 return 4;
    endcase
  endfunction

  // Expected output vector for cycle i of an instruction of class k.
  function automatic logic [17:0] model(input int k, input int i, input int len,
                                        input logic [5:0] f, input logic z, input logic r);
    logic pcw, irw, rw, wds, m2r, asb, ext, mw, lst, aphase;
    logic [1:0] rd, pcs;
    logic [2:0] alu, st;
    pcw = 0; irw = 0; rw = 0; wds = 0; m2r = 0; asb = 0; ext = 0; mw = 0;
    rd = 2'b01; pcs = 2'b00; alu = 3'b000;
    if (i == 0)            st = 3'd0;
    else if (i == 1)       st = 3'd1;
    else if (k == K_HALT)  st = 3'd7;
    else if (i == 2)       st = 3'd2;
    else if (i == 3)       st = (k == K_LW || k == K_SW) ? 3'd3 : 3'd4;
    else                   st = 3'd4;
    lst = (k != K_HALT) && (i == len - 1);
    irw = (i == 0);
    if (st == 3'd1 && k == K_JAL) begin rw = 1; rd = 2'b00; wds = 1; end
    aphase = (st == 3'd2 || st == 3'd4);
    if (aphase) begin
      asb = (k == K_ADDI || k == K_ORI || k == K_SLTI || k == K_LW || k == K_SW);
      ext = (k != K_ORI);
      case (k)
        K_R: case (f)
          6'b100010: alu = 3'd1;
          6'b100100: alu = 3'd2;
          6'b100101: alu = 3'd3;
          6'b101010: alu = 3'd4;
          default:   alu = 3'd0;
        endcase
        K_ORI:        alu = 3'd3;
        K_SLTI:       alu = 3'd4;
        K_BEQ, K_BNE: alu = 3'd1;
        default:      alu = 3'd0;
      endcase
    end
    if (st == 3'd3) mw = (k == K_SW);
    if (st == 3'd4) begin
      rw  = (k != K_RNOP);
      rd  = (k == K_R || k == K_RNOP) ? 2'b10 : 2'b01;
      m2r = (k == K_LW);
    end
    if (lst) begin
      pcw = 1;
      if (k == K_JR) pcs = 2'b10;
      else if (k == K_J || k == K_JAL) pcs = 2'b11;
      else if ((k == K_BEQ && z) || (k == K_BNE && !z)) pcs = 2'b01;
    end
    if (r) begin pcw = 0; irw = 0; rw = 0; mw = 0; end
    return {pcw, irw, rw, rd, wds, m2r, asb, ext, alu, pcs, mw, st};
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      logic [17:0] exp_v, got_v;
      exp_v = model(m_k, m_i, m_len, funct, zero, rst);
      got_v = {pc_wre, ir_wre, reg_wre, reg_dst, wr_data_src, mem_to_reg, alu_src_b,
               ext_sel, alu_op, pc_src, mem_wr, state};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL outputs t=%0t op=%b funct=%b cls=%0d cyc=%0d rst=%b got=%b exp=%b",
                 $time, op, funct, m_k, m_i, rst, got_v, exp_v);
      end
    end
  end

  task automatic lit(input string n, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", n, got, exp);
    end
  endtask

  // Hand-computed expectations for the directed scenarios.
  task automatic directed(input int dir, input int i);
    int add_st[4];
    add_st = '{0, 1, 2, 4};
    case (dir)
      1: begin
        lit("add_state", int'(state), add_st[i]);
        lit("add_pc_wre", int'(pc_wre), (i == 3) ? 1 : 0);
        if (i == 3) begin
          lit("add_wb_reg_wre", int'(reg_wre), 1);
          lit("add_wb_reg_dst", int'(reg_dst), 2);
          lit("add_wb_alu_op", int'(alu_op), 0);
        end
      end
      2: begin
        if (i == 3) lit("lw_mem_wr", int'(mem_wr), 0);
        if (i == 4) begin
          lit("lw_wb_mem_to_reg", int'(mem_to_reg), 1);
          lit("lw_wb_reg_dst", int'(reg_dst), 1);
          lit("lw_wb_alu_src_b", int'(alu_src_b), 1);
          lit("lw_wb_ext_sel", int'(ext_sel), 1);
        end
      end
      3, 4: if (i == 2) begin
        lit("br_pc_src", int'(pc_src), (dir == 3) ? 1 : 0);
        lit("br_pc_wre", int'(pc_wre), 1);
        lit("br_alu_op", int'(alu_op), 1);
      end
      5: if (i >= 2) begin
        lit("halt_state", int'(state), 7);
        lit("halt_enables", int'({pc_wre, ir_wre, reg_wre, mem_wr}), 0);
      end
      6: if (i == 3) begin
        lit("sw_rst_state", int'(state), 3);
        lit("sw_rst_mem_wr", int'(mem_wr), 0);
      end
      7: if (i == 1) begin
        lit("jal_id_vec", int'({reg_wre, reg_dst, wr_data_src, pc_src, pc_wre}), 7'b1_00_1_11_1);
      end
      default: ;
    endcase
  endtask

  task automatic run(input logic [5:0] o, input logic [5:0] f, input int rst_at_in,
                     input int hold, input int zf, input int dir);
    int k, len, rst_at;
    k = classify(o, f);
    rst_at = rst_at_in;
    len = (k == K_HALT) ? 3 + hold : cpi(k);
    if (k == K_HALT) rst_at = len - 1;
    op = o; funct = f; m_k = k; m_len = len;
    for (int i = 0; i < len; i++) begin
      m_i  = i;
      zero = (zf < 0) ? 1'($urandom_range(0, 1)) : zf[0];
      rst  = (i == rst_at);
      #1;
      directed(dir, i);
      @(posedge clk); #1;
      if (rst) begin
        rst = 1'b0;
        if (dir == 5 || dir == 6) lit("post_rst_state", int'(state), 0);
        break;
      end
    end
    rst = 1'b0;
  endtask

  task automatic pick(output logic [5:0] o, output logic [5:0] f);
    f = 6'($urandom_range(0, 63));
    case ($urandom_range(0, 18))
      0:  begin o = 6'b000000; f = 6'b100000; end
      1:  begin o = 6'b000000; f = 6'b100010; end
      2:  begin o = 6'b000000; f = 6'b100100; end
      3:  begin o = 6'b000000; f = 6'b100101; end
      4:  begin o = 6'b000000; f = 6'b101010; end
      5:  begin o = 6'b000000; f = 6'b001000; end
      6:  begin o = 6'b000000; f = 6'b000111; end
      7:  o = 6'b001000;
      8:  o = 6'b001101;
      9:  o = 6'b001010;
      10: o = 6'b100011;
      11: o = 6'b101011;
      12: o = 6'b000100;
      13: o = 6'b000101;
      14: o = 6'b000010;
      15: o = 6'b000011;
      16: o = 6'b111111;
      17: o = 6'b010000;
      default: o = 6'($urandom_range(0, 63));
    endcase
  endtask

  initial begin
    logic [5:0] o, f;
    rst = 1'b1; op = 6'b000000; funct = 6'b100000; zero = 1'b0;
    m_k = classify(op, funct); m_i = 0; m_len = 4;
    @(posedge clk); #1;
    m_valid = 1'b1;
    lit("reset_state", int'(state), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    run(6'b000000, 6'b100000, -1, 0, -1, 1);  // add
    run(6'b100011, 6'b000000, -1, 0, -1, 2);  // lw
    run(6'b000100, 6'b000000, -1, 0, 1, 3);   // beq taken
    run(6'b000100, 6'b000000, -1, 0, 0, 4);   // beq not taken
    run(6'b000101, 6'b000000, -1, 0, 0, 3);   // bne taken
    run(6'b000101, 6'b000000, -1, 0, 1, 4);   // bne not taken
    run(6'b000011, 6'b000000, -1, 0, -1, 7);  // jal
    run(6'b111111, 6'b000000, -1, 10, -1, 5); // halt
    run(6'b101011, 6'b000000, 3, 0, -1, 6);   // sw, reset in MEM
    run(6'b000000, 6'b000111, -1, 0, -1, 0);  // unknown funct
    run(6'b010000, 6'b000000, -1, 0, -1, 0);  // unknown opcode

    for (int n = 0; n < 400; n++) begin
      int ra;
      pick(o, f);
      ra = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) : -1;
      run(o, f, ra, int'($urandom_range(0, 5)), -1, 0);
    end

    @(negedge clk);
    m_valid = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
